sr_flop_bank: RTL and testbench
===============================

Name: sr_flop_bank

Overview:
- Parametrised, clocked successor to the team's gate-level NAND SR latch.
- Provides WIDTH independent synchronous set/clear flip-flops. Every bit updates on the clock edge only.
- The S=R=1 condition is legal: a run-time mode selects how it resolves. The block also detects and counts these conflicts.
- Used wherever sticky status or flag bits are needed: event flags, interrupt pending bits, handshake "seen" bits.

Parameters:
- WIDTH, 8, number of independent SR channels (1..32).
- CNT_W, 8, width of the saturating conflict counter (1..16).
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  update enable. When 0, every channel holds and no conflicts are recorded.
- mode  input  2  resolution of S=R=1: 00 hold, 01 set-dominant, 10 clear-dominant, 11 toggle.
- set  input  WIDTH  per-channel set request, active-high.
- clr  input  WIDTH  per-channel clear request, active-high.
- cnt_clr  input  1  synchronous clear of conflict_cnt and conflict_sticky.
- q  output  WIDTH  registered channel state.
- qbar  output  WIDTH  always the bitwise inverse of q. Never equal to q, including during and after reset.
- conflict  output  WIDTH  registered one-cycle pulse mask of channels that saw S=R=1 with en=1.
- conflict_sticky  output  1  set by any conflict; held until cnt_clr or reset.
- conflict_cnt  output  CNT_W  saturating count of cycles with at least one conflict.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - q=RESET_VAL, qbar=~RESET_VAL.
  - conflict=0, conflict_sticky=0, conflict_cnt=0.
  - Takes effect immediately, not at the next edge. Outputs stay there while reset is high.
- First update after reset: the first rising edge with reset low.
- Per channel i, on a rising clk edge with en=1:
  - set=1, clr=0: q[i] becomes 1.
  - set=0, clr=1: q[i] becomes 0.
  - set=0, clr=0: q[i] holds.
  - set=1, clr=1: resolved by mode, sampled on the same edge.
    - 00: hold.
    - 01: q[i] becomes 1.
    - 10: q[i] becomes 0.
    - 11: q[i] becomes ~q[i].
- en=0: q holds regardless of set, clr and mode.
  - conflict becomes 0 that edge.
  - conflict_sticky and conflict_cnt do not change, apart from cnt_clr.
- Latency: one clock from input to q, and one clock to conflict. Both are registered, with no combinational path from inputs to outputs.
- conflict[i] is 1 for exactly the cycle after an edge that saw en & set[i] & clr[i]. Back-to-back conflicts produce a continuous high.
- conflict_cnt:
  - Increments by 1 per edge where any channel has a conflict. It does not count popcount, so several conflicting channels in one cycle add only 1.
  - Saturates at 2^CNT_W-1 and never wraps.
- conflict_sticky: becomes 1 on any counted conflict edge.
- cnt_clr=1 at an edge:
  - conflict_cnt becomes 0 and conflict_sticky becomes 0.
  - Clear wins over a simultaneous conflict: the result is 0 and 0.
  - The conflict pulse mask is unaffected.
- A mode change takes effect on the edge where it is sampled. There is no pipeline and no state carries over between modes.
- All channels are fully independent. Simultaneous requests on different channels never interact.

Test Plan:
- Reset with RESET_VAL=8'hA5: assert reset between edges -> q=A5 and qbar=5A immediately, cnt=0. Release, then drive set=0, clr=0, en=1 for 3 cycles -> q stays A5.
- en=1, set=8'h0F, clr=8'hF0 from q=A5 -> after 1 edge q=0F, qbar=F0, conflict=00, cnt=0.
- From q=0F, set=clr=8'h11: mode=00 -> q=0F; mode=01 -> q=1F; mode=10 -> q=0E; mode=11 applied twice -> toggles 0E->1F->0E. Each edge gives conflict=11 and cnt increments 1..5.
- With CNT_W=2, 5 consecutive conflict cycles -> cnt goes 1,2,3,3,3 and sticky=1. cnt_clr together with a conflict -> cnt=0, sticky=0, conflict=mask still pulsed.
- en=0 with set=FF, clr=FF, mode=11 for 4 cycles -> q unchanged, conflict=00, cnt unchanged.
- Assert reset asynchronously mid-toggle sequence (mode=11, q toggling) -> q returns to RESET_VAL within the same cycle. After release, the first edge resumes per inputs and qbar==~q is checked every cycle.

Source files
------------

// File: rtl/sr_flop_bank.sv
// Bank of WIDTH independent clocked set/clear flip-flops with run-time S=R=1 resolution,
// per-channel conflict pulses, a sticky conflict flag and a saturating conflict counter.
module sr_flop_bank #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      CNT_W     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] set,
    input  logic [WIDTH-1:0] clr,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] conflict,
    output logic             conflict_sticky,
    output logic [CNT_W-1:0] conflict_cnt
);

    typedef enum logic [1:0] {
        ModeHold   = 2'b00,
        ModeSet    = 2'b01,
        ModeClr    = 2'b10,
        ModeToggle = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] conflict_q, conflict_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             any_conflict;
    mode_e            mode_sel;

    assign mode_sel = mode_e'(mode);

    // Per-channel next state; channels never look at each other.
    always_comb begin
        state_d = state_q;
        if (en) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                case ({set[i], clr[i]})
                    2'b10: state_d[i] = 1'b1;
                    2'b01: state_d[i] = 1'b0;
                    2'b11: begin
                        case (mode_sel)
                            ModeSet:    state_d[i] = 1'b1;
                            ModeClr:    state_d[i] = 1'b0;
                            ModeToggle: state_d[i] = ~state_q[i];
                            default:    state_d[i] = state_q[i];
                        endcase
                    end
                    default: state_d[i] = state_q[i];
                endcase
            end
        end
    end

    assign conflict_d   = en ? (set & clr) : '0;
    assign any_conflict = |conflict_d;

    // Clear beats a simultaneous conflict; the pulse mask is not affected by cnt_clr.
    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (cnt_clr) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end else if (any_conflict) begin
            sticky_d = 1'b1;
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RESET_VAL;
            conflict_q <= '0;
            sticky_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            conflict_q <= conflict_d;
            sticky_q   <= sticky_d;
            cnt_q      <= cnt_d;
        end
    end

    // qbar is derived from the same register so it can never match q.
    assign q               = state_q;
    assign qbar            = ~state_q;
    assign conflict        = conflict_q;
    assign conflict_sticky = sticky_q;
    assign conflict_cnt    = cnt_q;

endmodule

// File: tb/tb_sr_flop_bank.sv
// Randomised and directed bench for sr_flop_bank; two instances share stimulus so that
// an 8-bit and a 2-bit conflict counter are both checked against one behavioural model.
module tb_sr_flop_bank;

    localparam logic [7:0] RVAL = 8'hA5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] set = '0;
    logic [7:0] clr = '0;
    logic       cnt_clr = 1'b0;

    logic [7:0] q, qbar, conflict;
    logic       conflict_sticky;
    logic [7:0] conflict_cnt;
    logic [7:0] q2, qbar2, conflict2;
    logic       conflict_sticky2;
    logic [1:0] conflict_cnt2;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [7:0] m_q;
    logic [7:0] m_conf;
    logic       m_sticky;
    int         m_cnt;
    int         m_cnt2;

    sr_flop_bank #(.WIDTH(8), .CNT_W(8), .RESET_VAL(RVAL)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .set(set), .clr(clr),
        .cnt_clr(cnt_clr), .q(q), .qbar(qbar), .conflict(conflict),
        .conflict_sticky(conflict_sticky), .conflict_cnt(conflict_cnt)
    );

    sr_flop_bank #(.WIDTH(8), .CNT_W(2), .RESET_VAL(RVAL)) dut2 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .set(set), .clr(clr),
        .cnt_clr(cnt_clr), .q(q2), .qbar(qbar2), .conflict(conflict2),
        .conflict_sticky(conflict_sticky2), .conflict_cnt(conflict_cnt2)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_q      = RVAL;
        m_conf   = '0;
        m_sticky = 1'b0;
        m_cnt    = 0;
        m_cnt2   = 0;
    endfunction

    // One rising edge of the specified behaviour, written from the channel rules.
    function automatic void model_edge();
        logic [7:0] nq;
        logic [7:0] hits;
        if (reset) begin
            model_reset();
            return;
        end
        nq   = m_q;
        hits = '0;
        if (en) begin
            for (int i = 0; i < 8; i++) begin
                if (set[i] && !clr[i]) nq[i] = 1'b1;
                else if (!set[i] && clr[i]) nq[i] = 1'b0;
                else if (set[i] && clr[i]) begin
                    hits[i] = 1'b1;
                    if (mode == 2'd1) nq[i] = 1'b1;
                    else if (mode == 2'd2) nq[i] = 1'b0;
                    else if (mode == 2'd3) nq[i] = !m_q[i];
                end
            end
        end
        m_q    = nq;
        m_conf = hits;
        if (cnt_clr) begin
            m_cnt    = 0;
            m_cnt2   = 0;
            m_sticky = 1'b0;
        end else if (hits != 0) begin
            m_sticky = 1'b1;
            m_cnt    = (m_cnt  < 255) ? m_cnt + 1  : 255;
            m_cnt2   = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
        end
    endfunction

    task automatic check_all(input string tag);
        logic [7:0] exp_qbar;
        exp_qbar = ~m_q;
        check_eq({tag, ".q"},       q,                m_q);
        check_eq({tag, ".qbar"},    qbar,             exp_qbar);
        check_eq({tag, ".conf"},    conflict,         m_conf);
        check_eq({tag, ".sticky"},  conflict_sticky,  m_sticky);
        check_eq({tag, ".cnt"},     conflict_cnt,     m_cnt);
        check_eq({tag, ".q2"},      q2,               m_q);
        check_eq({tag, ".qbar2"},   qbar2,            exp_qbar);
        check_eq({tag, ".conf2"},   conflict2,        m_conf);
        check_eq({tag, ".sticky2"}, conflict_sticky2, m_sticky);
        check_eq({tag, ".cnt2"},    conflict_cnt2,    m_cnt2);
    endtask

    // Advance one edge, update the model, and check 1 ns later.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic e, input logic [1:0] m, input logic [7:0] s,
                         input logic [7:0] c, input logic cc);
        en      = e;
        mode    = m;
        set     = s;
        clr     = c;
        cnt_clr = cc;
    endtask

    initial begin
        logic [7:0] exp_modes [5];
        logic [1:0] mode_seq [5];
        logic [7:0] held;
        exp_modes[0] = 8'h0F; exp_modes[1] = 8'h1F; exp_modes[2] = 8'h0E;
        exp_modes[3] = 8'h1F; exp_modes[4] = 8'h0E;
        mode_seq[0] = 2'd0; mode_seq[1] = 2'd1; mode_seq[2] = 2'd2;
        mode_seq[3] = 2'd3; mode_seq[4] = 2'd3;

        // Async reset between edges must act immediately.
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        check_eq("rst_q_const", q, 8'hA5);
        check_eq("rst_qbar_const", qbar, 8'h5A);
        step("rst_held");
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 2'd0, 8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step("idle");
            check_eq("idle_q_const", q, 8'hA5);
        end

        drive(1'b1, 2'd0, 8'h0F, 8'hF0, 1'b0);
        step("setclr");
        check_eq("setclr_q_const", q, 8'h0F);
        check_eq("setclr_cnt_const", conflict_cnt, 0);

        // S=R=1 on channels 0 and 4 under every mode; 2-bit counter saturates.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, mode_seq[k], 8'h11, 8'h11, 1'b0);
            step("mode");
            check_eq("mode_q_const", q, exp_modes[k]);
            check_eq("mode_conf_const", conflict, 8'h11);
            check_eq("mode_cnt_const", conflict_cnt, k + 1);
            check_eq("mode_cnt2_const", conflict_cnt2, (k < 3) ? k + 1 : 3);
        end

        drive(1'b1, 2'd0, 8'h11, 8'h11, 1'b1);
        step("clr_vs_conf");
        check_eq("clr_cnt_const", conflict_cnt, 0);
        check_eq("clr_sticky_const", conflict_sticky, 0);
        check_eq("clr_conf_const", conflict, 8'h11);

        held = q;
        drive(1'b0, 2'd3, 8'hFF, 8'hFF, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step("en_off");
            check_eq("en_off_q", q, held);
        end

        // Reset asserted mid-cycle while channels are toggling.
        drive(1'b1, 2'd3, 8'hFF, 8'hFF, 1'b0);
        step("tog0");
        step("tog1");
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("rst_mid");
        check_eq("rst_mid_q_const", q, 8'hA5);
        #1 reset = 1'b0;
        step("tog_resume");
        check_eq("tog_resume_q_const", q, 8'h5A);

        // Randomised phase with occasional mid-cycle resets.
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
                  8'($urandom), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 39) == 0) begin
                #2 reset = 1'b1;
                #1;
                model_reset();
                check_all("rnd_rst");
                #1 reset = 1'b0;
            end
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
